fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch front end of the pipelined core. Owns the program counter, drives the synchronous instruction memory, and holds returned instructions in a 2-entry buffer so the IF/ID buffer and decode can stall without losing or duplicating an instruction. It sits directly upstream of `if_id_buf` and takes the branch/jump redirect resolved in the WB stage.

## Interface
- ADDR_W, 8, instruction-memory word-index width; `imem_addr = pc[ADDR_W-1:0]`
- clock  in  1  rising-edge clock for all state
- reset_n  in  1  asynchronous, active-low reset
- id_ready  in  1  decode accepts `instr_out`/`pc_out` this cycle when high
- redirect  in  1  taken branch/jump from WB; `branchControl`
- redirect_pc  in  32  target PC; `jumpAddress`
- imem_addr  out  ADDR_W  instruction-memory address
- imem_data  in  32  instruction word, valid in the cycle after its address was issued
- instr_out  out  32  head-of-buffer instruction
- pc_out  out  32  PC of `instr_out`
- instr_valid  out  1  buffer non-empty
- flush  out  1  equals `redirect`; kills younger instructions in the IF/ID and ID/EX buffers

## Operation
- State: `pc` (32 b), `inflight` (1 b), 2-entry FIFO of {pc, instr} (64 b each), `count` (0..2), read and write pointers (1 b each).
- pop = `instr_valid & id_ready & ~redirect`.
- issue = `~redirect & (count + inflight - pop < 2)`. This is the credit rule. The FIFO can never overflow.
- On issue: drive `imem_addr = pc[ADDR_W-1:0]`. At the edge, latch `req_pc <= pc`, set `pc <= pc + 1` (32-bit wrap: 0xFFFFFFFF → 0), and set `inflight <= 1`. With no issue, `inflight <= 0`. When idle, `imem_addr` still shows `pc[ADDR_W-1:0]`.
- Response: when `inflight` is 1 and there is no redirect, write {req_pc, imem_data} at the write pointer.
- Simultaneous push and pop: `count` stays the same and both pointers advance.
- Redirect has the highest priority over issue, pop and push. At the edge:
  - `pc <= redirect_pc`
  - `count <= 0`, both pointers `<= 0`
  - `inflight <= 0`, so the response returning in this cycle is discarded
- A redirect while stalled or while the FIFO is full behaves the same way. Back-to-back redirects: the last one wins.
- `instr_out`/`pc_out` show the FIFO head combinationally. When empty, they show 32'h0, which is the NOP encoding.
- Do not modify `imem_data`. Opcode and field decoding belongs to `if_id_buf`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `pc = 0`, `inflight = 0`, `count = 0`, pointers = 0
  - `instr_valid = 0`, `instr_out = 0`, `pc_out = 0`, `imem_addr = 0`
  - `flush` follows `redirect` only
- Reset deasserting mid-stream drops every buffered and in-flight instruction. Fetch restarts at PC 0.
- Latency: issue in cycle c, data returns in c+1, and is written at the end of c+1. `instr_valid` is high in c+2.
  - First valid instruction: the second cycle after reset release.
  - After a redirect edge: the issue cycle is the first cycle after the edge, so the target is valid in the cycle after next.
- Throughput is 1 instruction/cycle with `id_ready` held high. The steady state is `count = 1`, `inflight = 1`.
- Stall: at most one further response arrives after `id_ready` drops. `count` saturates at 2 and issue stops.
- When `id_ready` returns, the buffered entries drain one per cycle and issue resumes in the same cycle. There are no bubbles beyond the credit rule.

## Test plan
- Reset: hold `reset_n = 0` for 3 cycles, then release with `id_ready = 1`, imem model returning `0x1000 + addr`.
  - Required: all outputs 0 during reset.
  - Required: `instr_valid` rises in the 2nd cycle after release with pc 0 / 0x1000, then pc 1, 2, 3 on consecutive cycles.
- Stall: after pc 4 is presented, drop `id_ready` for 4 cycles.
  - Required: `count` reaches 2 and `imem_addr` stops advancing.
  - Required: on release, decode sees pc 4, 5, 6, … with no gap, loss or duplicate.
- Redirect with a full FIFO and a request in flight: `redirect = 1`, `redirect_pc = 0x40`.
  - Required: `flush = 1` in that cycle and `instr_valid = 0` next cycle.
  - Required: pc 0x40 is valid two cycles after the redirect edge, and no stale instruction ever appears.
- Redirect in the same cycle as `id_ready = 1` with `instr_valid = 1`: the head is not counted as consumed and the FIFO empties. Also drive redirects on two consecutive cycles (0x10, then 0x20): the stream resumes at 0x20.
- Wrap: redirect to 0xFFFFFFFF, `ADDR_W = 8`.
  - Required: `imem_addr` goes 0xFF then 0x00.
  - Required: `pc_out` goes 0xFFFFFFFF then 0x00000000.
- Reset mid-stream: assert `reset_n = 0` between edges while `count = 2`.
  - Required: `instr_valid` drops immediately.
  - Required: after release, fetch restarts at pc 0.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end. Owns the program counter, drives the
// synchronous instruction memory and parks returned instructions in a
// 2-entry buffer so decode can stall without losing or duplicating work.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   id_ready     decode accepts instr_out/pc_out this cycle
//   redirect     taken branch/jump resolved in WB
//   redirect_pc  branch/jump target PC
//   imem_addr    instruction-memory word address (pc[ADDR_W-1:0])
//   imem_data    instruction word, valid the cycle after its address
//   instr_out    head-of-buffer instruction (0 = NOP when empty)
//   pc_out       PC of instr_out (0 when empty)
//   instr_valid  buffer holds at least one instruction
//   flush        kills younger instructions downstream; mirrors redirect
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              id_ready,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic [31:0]       instr_out,
   output logic [31:0]       pc_out,
   output logic              instr_valid,
   output logic              flush
);

   logic [31:0] r_pc;
   logic [31:0] r_reqPc;
   logic        r_inflight;
   logic [31:0] r_fifoPc    [0:1];
   logic [31:0] r_fifoInstr [0:1];
   logic [1:0]  r_count;
   logic        r_rdPtr;
   logic        r_wrPtr;

   logic        w_pop;
   logic        w_push;
   logic        w_issue;
   logic [2:0]  w_credit;

   // Handshake decode. The credit sum counts every slot already spoken for
   // (buffered entries plus the one response on its way back) minus the
   // entry leaving this cycle; a new request is only allowed if it is
   // guaranteed a free slot when its data returns, so the buffer never
   // overflows. A pop can only happen with count >= 1, so the sum never
   // underflows.
   always_comb begin
      w_pop    = instr_valid & id_ready & ~redirect;
      w_push   = r_inflight & ~redirect;
      w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_issue  = ~redirect & (w_credit < 3'd2);
   end

   // Outputs. The memory address always tracks the PC, even when idle;
   // the head entry is presented combinationally and a NOP (all zeros)
   // is shown while the buffer is empty.
   always_comb begin
      imem_addr   = r_pc[ADDR_W-1:0];
      instr_valid = (r_count != 2'd0);
      flush       = redirect;
      instr_out   = 32'h0;
      pc_out      = 32'h0;
      if (instr_valid) begin
         instr_out = r_fifoInstr[r_rdPtr];
         pc_out    = r_fifoPc[r_rdPtr];
      end
   end

   // Fetch state. A redirect overrides everything else: the buffer is
   // emptied and the in-flight flag cleared so the response arriving in
   // the next cycle (fetched down the wrong path) is ignored. Otherwise a
   // push and a pop in the same cycle leave the count unchanged while both
   // pointers advance.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc           <= 32'h0;
         r_reqPc        <= 32'h0;
         r_inflight     <= 1'b0;
         r_count        <= 2'd0;
         r_rdPtr        <= 1'b0;
         r_wrPtr        <= 1'b0;
         r_fifoPc[0]    <= 32'h0;
         r_fifoPc[1]    <= 32'h0;
         r_fifoInstr[0] <= 32'h0;
         r_fifoInstr[1] <= 32'h0;
      end else if (redirect) begin
         r_pc       <= redirect_pc;
         r_inflight <= 1'b0;
         r_count    <= 2'd0;
         r_rdPtr    <= 1'b0;
         r_wrPtr    <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_reqPc <= r_pc;
            r_pc    <= r_pc + 32'd1;
         end
         if (w_push) begin
            r_fifoPc[r_wrPtr]    <= r_reqPc;
            r_fifoInstr[r_wrPtr] <= imem_data;
            r_wrPtr              <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
